// File: rtl/zephyr_loader.sv
// Program loader for the zephyr CPU: clears the 16-word RAM, streams an image into it,
// verifies a trailing checksum and only then releases the CPU from reset.
module zephyr_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   load_len_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic                  cpu_reset_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  in_ready_q, in_ready_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  len_ok;
  logic [DATA_WIDTH-1:0] data_sum;
  logic [CW-1:0]         count_inc;

  assign accept    = in_valid_i & in_ready_q;
  assign len_ok    = (load_len_i != '0) && (load_len_i <= DEPTH_C);
  assign data_sum  = sum_q + in_data_i;
  assign count_inc = count_q + CW'(1);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Every output register is loaded with the value for the state being entered,
  // so outputs line up with state_q instead of lagging it by a cycle.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    sum_d       = sum_q;
    in_ready_d  = in_ready_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start_i) begin
          len_d       = load_len_i;
          in_ready_d  = 1'b0;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          if (len_ok) begin
            state_d     = S_CLEAR;
            err_d       = 1'b0;
            count_d     = '0;
            sum_d       = '0;
            ram_we_d    = 1'b1;
            ram_addr_d  = '0;
            ram_wdata_d = '0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end

      S_CLEAR: begin
        if (ram_addr_q == LAST_ADDR) begin
          state_d    = S_LOAD;
          in_ready_d = 1'b1;
        end else begin
          ram_we_d    = 1'b1;
          ram_addr_d  = ram_addr_q + ADDR_WIDTH'(1);
          ram_wdata_d = '0;
        end
      end

      S_LOAD: begin
        if (accept) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = count_q[ADDR_WIDTH-1:0];
          ram_wdata_d = in_data_i;
          sum_d       = data_sum;
          count_d     = count_inc;
          if (count_inc == len_q) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (accept) begin
          in_ready_d = 1'b0;
          if (data_sum == '0) begin
            state_d     = S_RUN;
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready_o  = in_ready_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign cpu_reset_o = cpu_reset_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_zephyr_loader.sv
// Directed bench for zephyr_loader: RAM writes are scoreboarded against a queue of expected
// (address, data) pairs, and the written RAM image is compared with the intended image.
module tb_zephyr_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [4:0] load_len_i;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_ready_o;
  logic       ram_we_o;
  logic [3:0] ram_addr_o;
  logic [7:0] ram_wdata_o;
  logic       cpu_reset_o;
  logic       done_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  logic [7:0]  mem[16];
  logic [7:0]  exp_mem[16];
  logic [7:0]  img_buf[16];
  int          load_cnt;

  always #5 clk = ~clk;

  zephyr_loader dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .start_i     (start_i),
    .load_len_i  (load_len_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .cpu_reset_o (cpu_reset_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM write monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ram_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(ram_addr_o), 32'hFFFF);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(ram_addr_o), 32'(e[11:8]));
        chk("wr_data", 32'(ram_wdata_o), 32'(e[7:0]));
      end
      mem[ram_addr_o] = ram_wdata_o;
      $display("write addr=%0h data=%02h", ram_addr_o, ram_wdata_o);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready_o),  0);
    chk({tag, "_ram_we"},    32'(ram_we_o),    0);
    chk({tag, "_ram_addr"},  32'(ram_addr_o),  0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata_o), 0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset_o), 1);
    chk({tag, "_done"},      32'(done_o),      0);
    chk({tag, "_err"},       32'(err_o),       0);
  endtask

  // Called at a negedge; returns at the negedge after the START edge.
  task automatic do_start(input logic [4:0] len, input bit valid_len);
    start_i    = 1'b1;
    load_len_i = len;
    if (valid_len)
      for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'h00});
    @(posedge clk);
    @(negedge clk);
    start_i    = 1'b0;
    load_len_i = 5'd31;
    load_cnt   = 0;
  endtask

  // CLEAR must last exactly 16 cycles with IN_READY low; junk valid data is offered meanwhile.
  task automatic check_clear();
    in_valid_i = 1'b1;
    in_data_i  = 8'hEE;
    chk("clear_cpu_reset", 32'(cpu_reset_o), 1);
    chk("clear_done", 32'(done_o), 0);
    chk("clear_err", 32'(err_o), 0);
    for (int i = 0; i < 16; i++) begin
      chk("clear_in_ready", 32'(in_ready_o), 0);
      chk("clear_we", 32'(ram_we_o), 1);
      if (i == 15) in_valid_i = 1'b0;
      @(negedge clk);
    end
    chk("load_in_ready", 32'(in_ready_o), 1);
    chk("load_we_idle", 32'(ram_we_o), 0);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit push, input int gap);
    int n;
    in_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid_i = 1'b1;
    in_data_i  = d;
    n = 0;
    while (in_ready_o !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      chk("ready_timeout", 32'(in_ready_o), 1);
      in_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) begin
      exp_q.push_back({4'(load_cnt), d});
      load_cnt++;
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    in_data_i  = ~d;
  endtask

  task automatic verify_mem(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_ram%0d", tag, i), 32'(mem[i]), 32'(exp_mem[i]));
  endtask

  // Full load of img_buf[0..len-1] followed by checksum byte cks.
  task automatic load_image(input string tag, input int len, input logic [7:0] cks,
                            input bit gaps, input bit good);
    for (int i = 0; i < 16; i++) exp_mem[i] = (i < len) ? img_buf[i] : 8'h00;
    do_start(5'(len), 1'b1);
    check_clear();
    for (int i = 0; i < len; i++)
      send_byte(img_buf[i], 1'b1, gaps ? int'($urandom_range(0, 2)) : 0);
    send_byte(cks, 1'b0, 0);
    chk({tag, "_in_ready"},  32'(in_ready_o),  0);
    chk({tag, "_ram_we"},    32'(ram_we_o),    0);
    chk({tag, "_done"},      32'(done_o),      good ? 1 : 0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset_o), good ? 0 : 1);
    chk({tag, "_err"},       32'(err_o),       good ? 0 : 1);
    chk({tag, "_sb_empty"},  32'(exp_q.size()), 0);
    verify_mem(tag);
    $display("%s: image len=%0d checksum=%02h done=%0b err=%0b", tag, len, cks, done_o, err_o);
  endtask

  task automatic set_img1();
    img_buf[0] = 8'h4F; img_buf[1] = 8'h8D; img_buf[2] = 8'h5E; img_buf[3] = 8'h9C;
  endtask

  task automatic bad_len(input logic [4:0] len);
    do_start(len, 1'b0);
    chk("badlen_err", 32'(err_o), 1);
    chk("badlen_cpu_reset", 32'(cpu_reset_o), 1);
    chk("badlen_in_ready", 32'(in_ready_o), 0);
    for (int i = 0; i < 4; i++) begin
      chk("badlen_no_we", 32'(ram_we_o), 0);
      @(negedge clk);
    end
    $display("bad length %0d: err=%0b", len, err_o);
  endtask

  initial begin
    logic [7:0] s;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    load_len_i = '0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'hXX;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("reset");
    @(negedge clk);

    // Image 4F 8D 5E 9C sums to D6, so 2A completes it to zero.
    set_img1();
    load_image("t1", 4, 8'h2A, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    // Restart from RUN with a new image.
    img_buf[0] = 8'h01; img_buf[1] = 8'h02; img_buf[2] = 8'h03;
    load_image("t6", 3, 8'hFA, 1'b0, 1'b1);

    set_img1();
    load_image("t2", 4, 8'h2B, 1'b0, 1'b0);

    // Full-depth image with random valid gaps, restarted from ERROR.
    s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      img_buf[i] = 8'($urandom_range(0, 255));
      s = s + img_buf[i];
    end
    load_image("t4", 16, 8'h00 - s, 1'b1, 1'b1);

    // Abandon a load after two bytes.
    set_img1();
    do_start(5'd4, 1'b1);
    check_clear();
    send_byte(8'h4F, 1'b1, 0);
    send_byte(8'h8D, 1'b1, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    chk("midreset_sb_empty", 32'(exp_q.size()), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    bad_len(5'd0);
    bad_len(5'd17);

    set_img1();
    load_image("t5", 4, 8'h2A, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
